// File: rtl/fe_redirect_ctrl_pkg.sv
// fe_redirect_ctrl_pkg: shared fetch-control encodings and controller states
package fe_redirect_ctrl_pkg;
  localparam logic [1:0] JT_SEQ = 2'b00;
  localparam logic [1:0] JT_REG = 2'b01;
  localparam logic [1:0] JT_IMM = 2'b10;
  localparam logic [1:0] JT_INT = 2'b11;
  localparam logic [1:0] CTR_RUN = 2'b00;
  localparam logic [1:0] CTR_HOLD = 2'b10;
  typedef enum logic [1:0] {RUN, DRAIN, TAKE} state_t;
endpackage

// File: rtl/fe_redirect_ctrl_if.sv
// fe_redirect_ctrl_if: redirect/stall/interrupt sources in, fetch-control decisions out
interface fe_redirect_ctrl_if;
  logic stall_req;
  logic jr_valid;
  logic [31:0] jr_target;
  logic ji_valid;
  logic [31:0] ji_target;
  logic eret_valid;
  logic irq;
  logic [31:0] pc_cur;
  logic [1:0] ctr;
  logic [1:0] jmp_type;
  logic [31:0] jmp_r;
  logic [31:0] jmp_i;
  logic flush_id;
  logic flush_ex;
  logic int_ack;
  logic [31:0] epc;
  logic ie;
  modport master (
    output stall_req, jr_valid, jr_target, ji_valid, ji_target, eret_valid, irq, pc_cur,
    input ctr, jmp_type, jmp_r, jmp_i, flush_id, flush_ex, int_ack, epc, ie
  );
  modport slave (
    input stall_req, jr_valid, jr_target, ji_valid, ji_target, eret_valid, irq, pc_cur,
    output ctr, jmp_type, jmp_r, jmp_i, flush_id, flush_ex, int_ack, epc, ie
  );
endinterface

// File: rtl/fe_redirect_ctrl.sv
// fe_redirect_ctrl: arbitrates redirects, stalls and interrupts into fetch-PC control
module fe_redirect_ctrl
  import fe_redirect_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  fe_redirect_ctrl_if.slave bus
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DRAIN_CYCLES - 1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0] epc, epc_nxt, tgt;
  logic ie, ie_nxt, redir, take;
  assign redir = bus.eret_valid | bus.jr_valid | bus.ji_valid;
  assign take = state == TAKE;
  assign tgt = bus.eret_valid ? epc : bus.jr_valid ? bus.jr_target : bus.ji_target;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt <= '0;
      epc <= '0;
      ie <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      epc <= epc_nxt;
      ie <= ie_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    epc_nxt = epc;
    ie_nxt = bus.eret_valid ? 1'b1 : ie;
    case (state)
      RUN: if (!redir && bus.irq && ie) begin
        state_nxt = DRAIN;
        cnt_nxt = RELOAD;
      end
      DRAIN: begin
        if (bus.eret_valid) state_nxt = RUN;
        else if (redir) cnt_nxt = RELOAD;
        else if (cnt == '0) state_nxt = TAKE;
        else cnt_nxt = cnt - 1'b1;
      end
      TAKE: begin
        // a redirect wins this cycle; its target becomes the return point and the vector follows
        if (redir) epc_nxt = tgt;
        else begin
          state_nxt = RUN;
          epc_nxt = bus.pc_cur;
          ie_nxt = 1'b0;
        end
      end
      default: state_nxt = RUN;
    endcase
  end
  always_comb begin
    bus.jmp_type = (bus.eret_valid || bus.jr_valid) ? JT_REG : bus.ji_valid ? JT_IMM : take ? JT_INT : JT_SEQ;
    bus.jmp_r = bus.eret_valid ? epc : bus.jr_target;
    bus.jmp_i = bus.ji_target;
    bus.flush_id = redir | take;
    bus.flush_ex = take & ~redir;
    bus.int_ack = take & ~redir;
    bus.ctr = redir ? CTR_RUN : state == DRAIN ? CTR_HOLD : take ? CTR_RUN :
              ((bus.irq && ie) || bus.stall_req) ? CTR_HOLD : CTR_RUN;
    bus.epc = epc;
    bus.ie = ie;
  end
endmodule

// File: tb/tb_fe_redirect_ctrl.sv
// tb_fe_redirect_ctrl: directed scenario tasks checking fetch-control decisions and EPC/IE state
module tb_fe_redirect_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  fe_redirect_ctrl_if bus ();
  fe_redirect_ctrl #(.DRAIN_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  // {ctr, jmp_type, flush_id, flush_ex, int_ack}
  logic [6:0] ctl;
  assign ctl = {bus.ctr, bus.jmp_type, bus.flush_id, bus.flush_ex, bus.int_ack};

  task automatic clr();
    bus.stall_req = 0; bus.jr_valid = 0; bus.jr_target = 0; bus.ji_valid = 0;
    bus.ji_target = 0; bus.eret_valid = 0; bus.irq = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr(); bus.pc_cur = 32'h10; rst = 0;
    tick(); tick(); #1;
    checks++; if (ctl !== 7'b00_00_000) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0); end
    checks++; if (bus.jmp_r !== 32'h0) begin errors++; $display("FAIL reset_jmp_r got=%h exp=0", bus.jmp_r); end
    checks++; if ({bus.ie, bus.epc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL reset_ie_epc got=%b/%h exp=1/0", bus.ie, bus.epc); end
    rst = 1;
    tick(); #1;
    checks++; if (ctl !== 7'b00_00_000) begin errors++; $display("FAIL seq_ctl got=%b exp=%b", ctl, 7'b0); end
  endtask

  task automatic test_stall_vs_redirect();
    tick(); bus.stall_req = 1; bus.jr_valid = 1; bus.jr_target = 32'h200; #1;
    checks++; if (ctl !== 7'b00_01_100) begin errors++; $display("FAIL stall_jr_ctl got=%b exp=%b", ctl, 7'b00_01_100); end
    checks++; if (bus.jmp_r !== 32'h200) begin errors++; $display("FAIL stall_jr_target got=%h exp=200", bus.jmp_r); end
    tick(); bus.jr_valid = 0; #1;
    checks++; if (ctl !== 7'b10_00_000) begin errors++; $display("FAIL stall_only_ctl got=%b exp=%b", ctl, 7'b10_00_000); end
    tick(); bus.ji_valid = 1; bus.ji_target = 32'h300; #1;
    checks++; if (ctl !== 7'b00_10_100) begin errors++; $display("FAIL stall_ji_ctl got=%b exp=%b", ctl, 7'b00_10_100); end
    checks++; if (bus.jmp_i !== 32'h300) begin errors++; $display("FAIL stall_ji_target got=%h exp=300", bus.jmp_i); end
    clr();
  endtask

  task automatic test_irq_entry();
    tick(); bus.irq = 1; bus.pc_cur = 32'h40; #1;
    checks++; if (ctl !== 7'b10_00_000) begin errors++; $display("FAIL irq_detect_ctl got=%b exp=%b", ctl, 7'b10_00_000); end
    tick(); bus.irq = 0; #1;
    checks++; if (ctl !== 7'b10_00_000) begin errors++; $display("FAIL drain1_ctl got=%b exp=%b", ctl, 7'b10_00_000); end
    tick(); #1;
    checks++; if (ctl !== 7'b10_00_000) begin errors++; $display("FAIL drain2_ctl got=%b exp=%b", ctl, 7'b10_00_000); end
    tick(); #1;
    checks++; if (ctl !== 7'b00_11_111) begin errors++; $display("FAIL take_ctl got=%b exp=%b", ctl, 7'b00_11_111); end
    checks++; if ({bus.ie, bus.epc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL take_pre_state got=%b/%h exp=1/0", bus.ie, bus.epc); end
    tick(); bus.irq = 1; #1;
    checks++; if ({bus.ie, bus.epc} !== {1'b0, 32'h40}) begin errors++; $display("FAIL entry_state got=%b/%h exp=0/40", bus.ie, bus.epc); end
    checks++; if (ctl !== 7'b00_00_000) begin errors++; $display("FAIL irq_masked_ctl got=%b exp=%b", ctl, 7'b0); end
    tick(); #1;
    checks++; if (ctl !== 7'b00_00_000) begin errors++; $display("FAIL irq_masked2_ctl got=%b exp=%b", ctl, 7'b0); end
    clr();
  endtask

  task automatic test_eret();
    tick(); bus.eret_valid = 1; bus.jr_valid = 1; bus.jr_target = 32'h999; #1;
    checks++; if (ctl !== 7'b00_01_100) begin errors++; $display("FAIL eret_ctl got=%b exp=%b", ctl, 7'b00_01_100); end
    checks++; if (bus.jmp_r !== 32'h40) begin errors++; $display("FAIL eret_jmp_r got=%h exp=40", bus.jmp_r); end
    tick(); clr(); #1;
    checks++; if (bus.ie !== 1'b1) begin errors++; $display("FAIL eret_ie got=%b exp=1", bus.ie); end
    checks++; if (ctl !== 7'b00_00_000) begin errors++; $display("FAIL eret_after_ctl got=%b exp=%b", ctl, 7'b0); end
  endtask

  task automatic test_drain_redirect();
    tick(); bus.irq = 1; bus.pc_cur = 32'h50;
    tick(); bus.irq = 0; bus.ji_valid = 1; bus.ji_target = 32'h80; #1;
    checks++; if (ctl !== 7'b00_10_100) begin errors++; $display("FAIL drain_ji_ctl got=%b exp=%b", ctl, 7'b00_10_100); end
    tick(); clr(); bus.pc_cur = 32'h80; #1;
    checks++; if (ctl !== 7'b10_00_000) begin errors++; $display("FAIL drain_reload1_ctl got=%b exp=%b", ctl, 7'b10_00_000); end
    tick(); #1;
    checks++; if (ctl !== 7'b10_00_000) begin errors++; $display("FAIL drain_reload2_ctl got=%b exp=%b", ctl, 7'b10_00_000); end
    tick(); #1;
    checks++; if (ctl !== 7'b00_11_111) begin errors++; $display("FAIL drain_take_ctl got=%b exp=%b", ctl, 7'b00_11_111); end
    tick(); #1;
    checks++; if ({bus.ie, bus.epc} !== {1'b0, 32'h80}) begin errors++; $display("FAIL drain_epc got=%b/%h exp=0/80", bus.ie, bus.epc); end
    bus.eret_valid = 1; #1;
    checks++; if (bus.jmp_r !== 32'h80) begin errors++; $display("FAIL drain_eret_jmp_r got=%h exp=80", bus.jmp_r); end
    tick(); clr();
  endtask

  task automatic test_take_redirect();
    tick(); bus.irq = 1; bus.pc_cur = 32'h70;
    tick(); bus.irq = 0;
    tick(); tick(); bus.jr_valid = 1; bus.jr_target = 32'h123; #1;
    checks++; if (ctl !== 7'b00_01_100) begin errors++; $display("FAIL take_jr_ctl got=%b exp=%b", ctl, 7'b00_01_100); end
    tick(); clr(); bus.pc_cur = 32'h60; #1;
    checks++; if ({bus.ie, bus.epc} !== {1'b1, 32'h123}) begin errors++; $display("FAIL take_jr_epc got=%b/%h exp=1/123", bus.ie, bus.epc); end
    checks++; if (ctl !== 7'b00_11_111) begin errors++; $display("FAIL take_retry_ctl got=%b exp=%b", ctl, 7'b00_11_111); end
    tick(); #1;
    checks++; if ({bus.ie, bus.epc} !== {1'b0, 32'h60}) begin errors++; $display("FAIL take_retry_epc got=%b/%h exp=0/60", bus.ie, bus.epc); end
    bus.eret_valid = 1;
    tick(); clr();
  endtask

  task automatic test_reset_mid_drain();
    tick(); bus.irq = 1; bus.pc_cur = 32'h90;
    tick(); bus.irq = 0; #1;
    checks++; if (ctl !== 7'b10_00_000) begin errors++; $display("FAIL rst_pre_ctl got=%b exp=%b", ctl, 7'b10_00_000); end
    rst = 0; #1;
    checks++; if ({bus.ie, bus.epc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rst_mid_state got=%b/%h exp=1/0", bus.ie, bus.epc); end
    checks++; if (ctl !== 7'b00_00_000) begin errors++; $display("FAIL rst_mid_ctl got=%b exp=%b", ctl, 7'b0); end
    tick(); rst = 1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      checks++; if (ctl !== 7'b00_00_000) begin errors++; $display("FAIL rst_after_ctl%0d got=%b exp=%b", i, ctl, 7'b0); end
    end
    checks++; if (bus.epc !== 32'h0) begin errors++; $display("FAIL rst_after_epc got=%h exp=0", bus.epc); end
  endtask

  initial begin
    test_reset();
    test_stall_vs_redirect();
    test_irq_entry();
    test_eret();
    test_drain_redirect();
    test_take_redirect();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fe_redirect_ctrl.md
# fe_redirect_ctrl

Sequencing controller for the fetch stage. Each cycle it decides what the fetch PC does next: advance, hold, take a jump-register, take a jump-immediate, take the interrupt vector, or return from interrupt. It arbitrates redirect, stall and interrupt sources into the fetch stage's `ctr`/`jmp_type`/`jmp_r`/`jmp_i` inputs, and owns the interrupt-enable and EPC state. It sits between the decode/execute hazard and branch logic and the fetch stage.

## Interface
- `DRAIN_CYCLES`, default 2: cycles fetch is held after interrupt acceptance so in-flight instructions retire.
- `clk  input  1`: clock, rising edge.
- `rst  input  1`: reset, asynchronous, active-low.
- `stall_req  input  1`: decode hazard; hold fetch PC.
- `jr_valid  input  1`, `jr_target  input  32`: jump-register from EX.
- `ji_valid  input  1`, `ji_target  input  32`: jump-immediate from ID.
- `eret_valid  input  1`: return-from-interrupt resolved in EX.
- `irq  input  1`: level interrupt request.
- `pc_cur  input  32`: current fetch PC.
- `ctr  output  2`: `2'b10` = hold, `2'b00` = advance.
- `jmp_type  output  2`: 00 seq, 01 reg, 10 imm, 11 interrupt.
- `jmp_r  output  32`: register target (`jr_target` or EPC).
- `jmp_i  output  32`: equals `ji_target`.
- `flush_id  output  1`: kill the instruction in ID.
- `flush_ex  output  1`: kill the instruction in EX.
- `int_ack  output  1`: one-cycle pulse on interrupt entry.
- `epc  output  32`: saved return PC.
- `ie  output  1`: interrupt enable.

## Operation
- States: RUN, DRAIN, TAKE.
- **Priority, every state (highest first):**
  1. `eret_valid`: `jmp_type=01`, `jmp_r=epc`, `flush_id=1`, `ie<=1`.
  2. `jr_valid`: `jmp_type=01`, `jmp_r=jr_target`, `flush_id=1`.
  3. `ji_valid`: `jmp_type=10`, `flush_id=1`.
  4. interrupt or stall handling as below.
  5. sequential: `jmp_type=00`.
- A redirect always overrides `stall_req`. When a redirect is taken, `ctr=00`.
- **RUN:**
  - `irq & ie` with no redirect in that cycle: go to DRAIN, load `cnt=DRAIN_CYCLES-1`, `ctr=10`.
  - `irq & ie` in the same cycle as a redirect: take the redirect and stay in RUN. Re-evaluate `irq` next cycle.
  - Otherwise `ctr = stall_req ? 10 : 00`.
- **DRAIN:**
  - `ctr=10` unless a redirect is taken.
  - `cnt` decrements each cycle. `cnt==0` moves to TAKE.
  - A redirect in DRAIN is taken, reloads `cnt=DRAIN_CYCLES-1`, and stays in DRAIN.
  - `eret_valid` in DRAIN aborts to RUN; `ie` is already 1.
  - `irq` deasserting in DRAIN does not cancel; the interrupt is committed.
- **TAKE (one cycle):**
  - `jmp_type=11`, `ctr=00`, `epc<=pc_cur`, `ie<=0`, `int_ack=1`, `flush_id=1`, `flush_ex=1`. Then RUN.
  - A redirect arriving in TAKE is taken instead of the interrupt and also sets `epc<=` the redirect target. The interrupt vector is still taken next cycle (stay in TAKE).
- `ie` clears only in TAKE and sets only on `eret_valid`. `irq` is ignored while `ie=0`.
- The counter is `$clog2(DRAIN_CYCLES+1)` bits. With `DRAIN_CYCLES=1`, DRAIN lasts one cycle.

## Timing
- Outputs `ctr`, `jmp_type`, `jmp_r`, `jmp_i`, `flush_*` and `int_ack` are combinational from inputs and state. The fetch PC reflects the decision at the next rising edge.
- `epc`, `ie` and the state are registered.
- Reset values: state RUN, `cnt=0`, `epc=0`, `ie=1`. With all inputs low, outputs are `ctr=00`, `jmp_type=00`, `jmp_r=0`, flushes 0, `int_ack=0`.
- Reset asserted mid-DRAIN or mid-TAKE returns to RUN immediately. No `int_ack` is produced and `epc` is cleared.
- Interrupt latency, with no redirects: `irq` high at edge N → DRAIN from N+1 → TAKE at N+1+`DRAIN_CYCLES` → vector PC at the following edge.

## Structure
- Shared package: `JT_SEQ`, `JT_REG`, `JT_IMM`, `JT_INT` (2-bit), `CTR_RUN=2'b00`, `CTR_HOLD=2'b10`, and the state enum. The fetch stage uses the same constants.
- No sub-module. One state register, one down-counter, EPC/IE registers, and a priority mux.

## Test plan
- **Reset and sequential:** reset low, then high, no requests → `ctr=00`, `jmp_type=00`, `ie=1`, `epc=0`.
- **Stall vs. redirect:** `stall_req=1` with `jr_valid=1`, `jr_target=0x200` → `ctr=00`, `jmp_type=01`, `jmp_r=0x200`, `flush_id=1`. With `stall_req=1` alone → `ctr=10`.
- **Interrupt entry:** `irq=1`, `pc_cur=0x40`, `DRAIN_CYCLES=2` → 2 cycles `ctr=10`, then TAKE with `jmp_type=11`, `int_ack=1`, `epc=0x40`, `ie=0`. A second `irq` is ignored.
- **Redirect during DRAIN:** `ji_valid=1`, `ji_target=0x80` in the first DRAIN cycle → `jmp_type=10`, `cnt` reloaded, so TAKE comes 2 cycles later with `epc=0x80` (`pc_cur`).
- **Return:** `eret_valid=1` after entry → `jmp_type=01`, `jmp_r=epc`, `ie=1`. Both `eret_valid` and `jr_valid` high → eret wins.
- **Reset mid-DRAIN:** drop `rst` during DRAIN → state RUN, `int_ack` never pulses, `epc=0`.
